// File: rtl/and_reduce_seq_if.sv
// Handshake bundle for and_reduce_seq: operand stream in, reduced result out.
// Modports: master is the producer/consumer side, slave is the reducer.
interface and_reduce_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/and_reduce_seq.sv
// Bitwise AND of NOPS operands through one shared accumulator; result valid the cycle after the last operand.
// Holds the result in DONE while out_ready is low; in_ready is low in DONE, so operands wait upstream.
module and_reduce_seq #(
  parameter int WIDTH = 4,
  parameter int NOPS  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  and_reduce_seq_if.slave      bus,
  output logic                 busy,
  output logic [7:0]           op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(NOPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  // Handshake outputs decode state only; no path from in_valid or out_ready.
  assign bus.in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = acc_q;
  assign bus.out_zero  = (acc_q == '0);
  assign busy          = (state_q == ACC) || (state_q == DONE);
  assign op_cnt        = cnt_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      // Abort wins over any transfer in the same cycle.
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            acc_d   = bus.in_data;
            cnt_d   = 8'd1;
            state_d = (NOPS == 1) ? DONE : ACC;
          end
        end
        ACC: begin
          if (in_xfer) begin
            acc_d = acc_q & bus.in_data;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_xfer) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_and_reduce_seq.sv
// Bench for and_reduce_seq: NOPS=3 instance driven from a vector table and hand sequences,
// plus a NOPS=1 instance; results are scoreboarded through a queue.
module tb_and_reduce_seq;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] exp;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic       zero;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       clr1;
  logic       busy3, busy1;
  logic [7:0] op_cnt3, op_cnt1;

  int   checks;
  int   errors;
  res_t sb[$];
  vec_t vecs[6];

  and_reduce_seq_if #(.WIDTH(4)) bus3 ();
  and_reduce_seq_if #(.WIDTH(4)) bus1 ();

  and_reduce_seq #(.WIDTH(4), .NOPS(3)) u_dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .bus    (bus3.slave),
    .busy   (busy3),
    .op_cnt (op_cnt3)
  );

  and_reduce_seq #(.WIDTH(4), .NOPS(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr1),
    .bus    (bus1.slave),
    .busy   (busy1),
    .op_cnt (op_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one operand to the NOPS=3 instance until accepted (bounded).
  task automatic send(input logic [3:0] d);
    int   n;
    logic rdy;
    n             = 0;
    bus3.in_valid = 1'b1;
    bus3.in_data  = d;
    do begin
      @(negedge clk);
      rdy = bus3.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    bus3.in_valid = 1'b0;
    chk("send_accepted", int'(rdy), 1);
  endtask

  // Scoreboard: every output transfer of the NOPS=3 instance must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && !clr && bus3.out_valid && bus3.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h required no output at %0t", bus3.out_data, $time);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("result_data", int'(bus3.out_data), int'(e.data));
        chk("result_zero", int'(bus3.out_zero), int'(e.zero));
      end
    end
  end

  initial begin
    vecs[0] = '{a: 4'hF, b: 4'hA, c: 4'h6, exp: 4'h2, zero: 1'b0};
    vecs[1] = '{a: 4'hF, b: 4'hF, c: 4'hF, exp: 4'hF, zero: 1'b0};
    vecs[2] = '{a: 4'h0, b: 4'hF, c: 4'hF, exp: 4'h0, zero: 1'b1};
    vecs[3] = '{a: 4'h8, b: 4'hC, c: 4'hE, exp: 4'h8, zero: 1'b0};
    vecs[4] = '{a: 4'h5, b: 4'hA, c: 4'hF, exp: 4'h0, zero: 1'b1};
    vecs[5] = '{a: 4'h7, b: 4'hB, c: 4'hD, exp: 4'h1, zero: 1'b0};

    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    clr            = 1'b0;
    clr1           = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = 4'h0;
    bus3.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 4'h0;
    bus1.out_ready = 1'b1;

    #2;
    chk("rst_out_valid", int'(bus3.out_valid), 0);
    chk("rst_in_ready",  int'(bus3.in_ready), 1);
    chk("rst_busy",      int'(busy3), 0);
    chk("rst_op_cnt",    int'(op_cnt3), 0);
    chk("rst_acc",       int'(bus3.out_data), 0);
    chk("rst_zero",      int'(bus3.out_zero), 1);
    chk("rst1_in_ready", int'(bus1.in_ready), 1);
    chk("rst1_busy",     int'(busy1), 0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back reductions from the table, out_ready held high.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a);
      send(vecs[i].b);
      sb.push_back('{data: vecs[i].exp, zero: vecs[i].zero});
      send(vecs[i].c);
      @(negedge clk);
      chk("done_out_valid", int'(bus3.out_valid), 1);
      chk("done_in_ready",  int'(bus3.in_ready), 0);
      chk("done_busy",      int'(busy3), 1);
      chk("done_op_cnt",    int'(op_cnt3), 3);
      @(negedge clk);
      chk("after_out_valid", int'(bus3.out_valid), 0);
      chk("after_in_ready",  int'(bus3.in_ready), 1);
      chk("after_busy",      int'(busy3), 0);
      chk("after_op_cnt",    int'(op_cnt3), 0);
      @(posedge clk);
      #1;
    end

    // Operands C, 3, F with 2-cycle gaps.
    begin
      logic [3:0] ops[3];
      ops[0] = 4'hC;
      ops[1] = 4'h3;
      ops[2] = 4'hF;
      for (int k = 0; k < 3; k++) begin
        if (k == 2) sb.push_back('{data: 4'h0, zero: 1'b1});
        send(ops[k]);
        @(negedge clk);
        chk("gap_op_cnt", int'(op_cnt3), k + 1);
        if (k < 2) begin
          @(negedge clk);
          chk("gap_op_cnt_hold", int'(op_cnt3), k + 1);
          @(posedge clk);
          #1;
        end
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: result 2 held for 5 cycles while operand 5 is offered.
    bus3.out_ready = 1'b0;
    send(4'hF);
    send(4'hA);
    sb.push_back('{data: 4'h2, zero: 1'b0});
    send(4'h6);
    bus3.in_valid = 1'b1;
    bus3.in_data  = 4'h5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(bus3.out_valid), 1);
      chk("bp_out_data",  int'(bus3.out_data), 2);
      chk("bp_in_ready",  int'(bus3.in_ready), 0);
      chk("bp_op_cnt",    int'(op_cnt3), 3);
    end
    @(posedge clk);
    #1;
    bus3.in_valid  = 1'b0;
    bus3.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid",  int'(bus3.out_valid), 0);
    chk("bp_release_op_cnt", int'(op_cnt3), 0);
    @(posedge clk);
    #1;

    // clr coincident with the third operand drops it.
    send(4'hF);
    send(4'h7);
    bus3.in_valid = 1'b1;
    bus3.in_data  = 4'h1;
    clr           = 1'b1;
    @(posedge clk);
    #1;
    clr           = 1'b0;
    bus3.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("clr_out_valid", int'(bus3.out_valid), 0);
      chk("clr_op_cnt",    int'(op_cnt3), 0);
      chk("clr_busy",      int'(busy3), 0);
    end
    @(posedge clk);
    #1;
    send(4'h9);
    send(4'h9);
    sb.push_back('{data: 4'h1, zero: 1'b0});
    send(4'h1);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-reduction.
    send(4'h3);
    @(negedge clk);
    chk("prerst_op_cnt", int'(op_cnt3), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(bus3.in_ready), 1);
    chk("arst_busy",     int'(busy3), 0);
    chk("arst_op_cnt",   int'(op_cnt3), 0);
    chk("arst_out_valid", int'(bus3.out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'hE);
    send(4'hE);
    sb.push_back('{data: 4'hE, zero: 1'b0});
    send(4'hE);
    repeat (2) @(posedge clk);
    #1;

    // NOPS=1: stream 3 then 8, one result every 2 cycles.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'h3;
    @(posedge clk);
    #1;
    bus1.in_data = 4'h8;
    @(negedge clk);
    chk("n1_valid_a", int'(bus1.out_valid), 1);
    chk("n1_data_a",  int'(bus1.out_data), 3);
    chk("n1_ready_a", int'(bus1.in_ready), 0);
    @(negedge clk);
    chk("n1_valid_gap", int'(bus1.out_valid), 0);
    chk("n1_ready_gap", int'(bus1.in_ready), 1);
    @(negedge clk);
    chk("n1_valid_b", int'(bus1.out_valid), 1);
    chk("n1_data_b",  int'(bus1.out_data), 8);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("n1_final_valid", int'(bus1.out_valid), 0);
    chk("n1_final_cnt",   int'(op_cnt1), 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_reduce_seq.md
Name: and_reduce_seq

Overview:
Sequencer that shares one WIDTH-bit 2-input AND datapath to compute the bitwise AND of NOPS operands, one operand per cycle (acc = op0; acc = acc & op1; ... acc = acc & op[NOPS-1]).
- Operands enter through a valid/ready input port.
- The reduced result leaves through a valid/ready output port.
- Replaces wide multi-input AND gates in the lab datapath with a single registered accumulator and a control FSM.

Parameters:
WIDTH, 4, bit width of each operand and of the result.
NOPS, 3, operands per reduction; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort; discards the reduction in progress.
in_valid  input  1  operand present on in_data.
in_ready  output  1  block accepts an operand this cycle.
in_data  input  WIDTH  operand.
out_valid  output  1  result present on out_data.
out_ready  input  1  consumer takes the result this cycle.
out_data  output  WIDTH  reduced AND result (the accumulator).
out_zero  output  1  high when out_data == 0; meaningful only while out_valid.
busy  output  1  high in ACC or DONE.
op_cnt  output  8  number of operands accepted in the current reduction.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, op_cnt=0.
  - out_valid=0, busy=0, in_ready=1 (combinational from state after reset release).
- Transfers:
  - Input transfer = in_valid & in_ready at the rising edge.
  - Output transfer = out_valid & out_ready at the rising edge.
- States: IDLE, ACC, DONE (2-bit encoding; the unused code returns to IDLE).
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On input transfer: acc<=in_data, op_cnt<=1.
  - Next state is DONE if NOPS==1, otherwise ACC.
- ACC:
  - in_ready=1, busy=1.
  - On input transfer: acc<=acc & in_data, op_cnt<=op_cnt+1.
  - If op_cnt==NOPS-1 before the increment, next state is DONE.
  - Cycles with in_valid=0 hold acc and op_cnt unchanged; gaps are unlimited.
- DONE:
  - in_ready=0, out_valid=1, busy=1; out_data=acc and is stable while waiting.
  - On output transfer: next state IDLE, op_cnt<=0; acc is held until the next first operand.
  - out_ready low: stay in DONE indefinitely (backpressure).
- Latency and throughput:
  - out_valid rises the cycle after the last operand transfer.
  - Minimum period per reduction is NOPS+1 cycles (DONE->IDLE costs one cycle; no accept in DONE).
- clr:
  - Any state goes to IDLE, op_cnt<=0, out_valid drops next cycle.
  - clr has priority over a simultaneous input or output transfer; that operand or result is dropped.
  - clr in IDLE is a no-op apart from blocking that cycle's transfer.
- Outputs:
  - out_zero = (acc == 0), registered path through acc only.
  - in_ready and out_valid are decoded from state only; no combinational path from in_valid or out_ready.
- Widths:
  - op_cnt saturates by construction at NOPS.
  - The AND is pure bitwise; no carry, sign or width extension.
- Asynchronous reset mid-reduction: all partial state is lost; the bench must see IDLE outputs within the same cycle as rst_n low.

Test Plan:
- WIDTH=4, NOPS=3, back-to-back operands 4'hF, 4'hA, 4'h6 with out_ready=1:
  - out_valid high exactly 1 cycle, out_data=4'h2, out_zero=0.
  - in_ready low in that cycle, IDLE the cycle after.
- Operands 4'hC, 4'h3, 4'hF with 2-cycle in_valid gaps:
  - op_cnt steps 1, 2, 3; out_data=4'h0; out_zero=1.
- Result 4'h2 pending with out_ready held low for 5 cycles:
  - out_valid and out_data=4'h2 stable for all 5 cycles, in_ready=0.
  - Operand 4'h5 offered meanwhile is not consumed.
- After 2 operands (4'hF, 4'h7), assert clr in the same cycle as the third operand:
  - Third operand is dropped, state=IDLE, op_cnt=0, out_valid never rises.
  - New sequence 4'h9, 4'h9, 4'h1 yields 4'h1.
- rst_n pulsed low for 1 cycle after 1 operand:
  - Outputs immediately reset (in_ready=1, busy=0, op_cnt=0).
  - The following 3 operands 4'hE, 4'hE, 4'hE yield 4'hE.
- NOPS=1:
  - Each operand produces a result the next cycle.
  - Stream 4'h3, 4'h8 with out_ready=1 gives 4'h3 then 4'h8, one result every 2 cycles.
